// File: rtl/vc_wrr_arbiter_if.sv
// rtl/vc_wrr_arbiter_if.sv - weight config, per-VC source streams and merged destination stream
interface vc_wrr_arbiter_if #(
    parameter int N_VC      = 4,
    parameter int DATA_SIZE = 32,
    parameter int WEIGHT_W  = 4
);
    localparam int IDX_W = $clog2(N_VC);

    logic [N_VC*WEIGHT_W-1:0]  cfg_weight_i;
    logic [N_VC-1:0]           src_valid_i;
    logic [N_VC-1:0]           src_last_i;
    logic [N_VC*DATA_SIZE-1:0] src_data_i;
    logic [N_VC-1:0]           src_ready_o;
    logic                      dst_valid_o;
    logic                      dst_ready_i;
    logic [DATA_SIZE-1:0]      dst_data_o;
    logic                      dst_last_o;
    logic [IDX_W-1:0]          dst_vc_o;

    modport slave (
        input  cfg_weight_i,
        input  src_valid_i,
        input  src_last_i,
        input  src_data_i,
        output src_ready_o,
        output dst_valid_o,
        input  dst_ready_i,
        output dst_data_o,
        output dst_last_o,
        output dst_vc_o
    );

    modport master (
        output cfg_weight_i,
        output src_valid_i,
        output src_last_i,
        output src_data_i,
        input  src_ready_o,
        input  dst_valid_o,
        output dst_ready_i,
        input  dst_data_o,
        input  dst_last_o,
        input  dst_vc_o
    );
endinterface

// File: rtl/vc_wrr_arbiter.sv
// rtl/vc_wrr_arbiter.sv - packet-aware weighted round-robin merge of N_VC beat streams
module vc_wrr_arbiter #(
    parameter int N_VC      = 4,
    parameter int DATA_SIZE = 32,
    parameter int WEIGHT_W  = 4
) (
    input  logic               clk,
    input  logic               rst_n,
    vc_wrr_arbiter_if.slave    bus
);
    localparam int                IDX_W   = $clog2(N_VC);
    localparam logic [IDX_W-1:0]  LAST_VC = IDX_W'(N_VC - 1);

    // ST_FRESH: no phase since reset, so the first grant always comes from the scan
    typedef enum logic [1:0] {
        ST_FRESH  = 2'd0,
        ST_OPEN   = 2'd1,
        ST_LOCKED = 2'd2
    } arb_state_t;

    arb_state_t              r_state;
    arb_state_t              w_state_nxt;
    logic [IDX_W-1:0]        r_cur;
    logic [WEIGHT_W-1:0]     r_cnt;

    logic                    r_dst_valid;
    logic [DATA_SIZE-1:0]    r_dst_data;
    logic                    r_dst_last;
    logic [IDX_W-1:0]        r_dst_vc;

    logic [WEIGHT_W-1:0]     w_weight [N_VC];
    logic [N_VC-1:0]         w_elig;
    logic                    w_scan_found;
    logic [IDX_W-1:0]        w_scan_idx;
    logic [IDX_W-1:0]        w_scan_try;
    logic                    w_sel_valid;
    logic [IDX_W-1:0]        w_sel;
    logic                    w_new_phase;
    logic                    w_accept;
    logic                    w_xfer;
    logic                    w_sel_last;
    logic [DATA_SIZE-1:0]    w_sel_data;
    logic [N_VC-1:0]         w_ready;

    genvar gi;
    generate
        for (gi = 0; gi < N_VC; gi++) begin : g_ch
            assign w_weight[gi] = bus.cfg_weight_i[gi*WEIGHT_W +: WEIGHT_W];
            assign w_elig[gi]   = bus.src_valid_i[gi] && (w_weight[gi] != '0);
        end
    endgenerate

    // Rotating search starting one past the current owner; the owner itself is tried last
    always_comb begin
        w_scan_found = 1'b0;
        w_scan_idx   = '0;
        w_scan_try   = '0;
        for (int k = 1; k <= N_VC; k++) begin
            w_scan_try = IDX_W'((int'(r_cur) + k) % N_VC);
            if (!w_scan_found && w_elig[w_scan_try]) begin
                w_scan_found = 1'b1;
                w_scan_idx   = w_scan_try;
            end
        end
    end

    always_comb begin
        w_sel_valid = 1'b0;
        w_sel       = r_cur;
        w_new_phase = 1'b0;
        if (r_state == ST_LOCKED) begin
            w_sel_valid = 1'b1;
        end else if ((r_state == ST_OPEN) && w_elig[r_cur] && (r_cnt < w_weight[r_cur])) begin
            w_sel_valid = 1'b1;
        end else if (w_scan_found) begin
            w_sel_valid = 1'b1;
            w_sel       = w_scan_idx;
            w_new_phase = 1'b1;
        end
    end

    assign w_accept   = !r_dst_valid || bus.dst_ready_i;
    assign w_sel_last = bus.src_last_i[w_sel];
    assign w_sel_data = bus.src_data_i[int'(w_sel)*DATA_SIZE +: DATA_SIZE];
    assign w_xfer     = w_sel_valid && w_accept && bus.src_valid_i[w_sel];

    always_comb begin
        w_ready = '0;
        if (w_sel_valid && w_accept) begin
            w_ready[w_sel] = 1'b1;
        end
    end

    always_comb begin
        w_state_nxt = r_state;
        if (w_xfer) begin
            w_state_nxt = w_sel_last ? ST_OPEN : ST_LOCKED;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state <= ST_FRESH;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    // Quota counter counts completed TLPs of the current phase; bounded by the weight
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_cur <= LAST_VC;
            r_cnt <= '0;
        end else if (w_xfer) begin
            r_cur <= w_sel;
            if (w_new_phase) begin
                r_cnt <= WEIGHT_W'(w_sel_last);
            end else begin
                r_cnt <= r_cnt + WEIGHT_W'(w_sel_last);
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_dst_valid <= 1'b0;
            r_dst_data  <= '0;
            r_dst_last  <= 1'b0;
            r_dst_vc    <= '0;
        end else if (w_xfer) begin
            r_dst_valid <= 1'b1;
            r_dst_data  <= w_sel_data;
            r_dst_last  <= w_sel_last;
            r_dst_vc    <= w_sel;
        end else if (bus.dst_ready_i) begin
            r_dst_valid <= 1'b0;
        end
    end

    assign bus.src_ready_o = w_ready;
    assign bus.dst_valid_o = r_dst_valid;
    assign bus.dst_data_o  = r_dst_data;
    assign bus.dst_last_o  = r_dst_last;
    assign bus.dst_vc_o    = r_dst_vc;
endmodule

// File: tb/tb_vc_wrr_arbiter.sv
// tb/tb_vc_wrr_arbiter.sv - directed and randomized checks of vc_wrr_arbiter against a TLP-level model
module tb_vc_wrr_arbiter;
    localparam int N_VC      = 4;
    localparam int DATA_SIZE = 32;
    localparam int WEIGHT_W  = 4;

    logic clk   = 1'b0;
    logic rst_n = 1'b0;
    always #5 clk = ~clk;

    vc_wrr_arbiter_if #(.N_VC(N_VC), .DATA_SIZE(DATA_SIZE), .WEIGHT_W(WEIGHT_W)) bus ();

    vc_wrr_arbiter #(.N_VC(N_VC), .DATA_SIZE(DATA_SIZE), .WEIGHT_W(WEIGHT_W)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    int checks   = 0;
    int failures = 0;

    int               weight [N_VC];
    bit               want   [N_VC];
    bit               dready;
    logic [DATA_SIZE:0] srcq [N_VC][$];   // {last, data} beats waiting at each source
    int               vc_log [$];         // channel of every beat accepted downstream

    // Model: phase owner, whole TLPs sent this phase, mid-TLP flag, plus the output slot
    int                   m_owner;
    int                   m_tlps;
    bit                   m_mid;
    bit                   m_started;
    bit                   m_valid;
    logic [DATA_SIZE-1:0] m_data;
    bit                   m_last;
    int                   m_vc;

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    function automatic bit present(input int c);
        return want[c] && (srcq[c].size() > 0);
    endfunction

    function automatic bit elig(input int c);
        return present(c) && (weight[c] != 0);
    endfunction

    task automatic push_tlp(input int c, input int len);
        for (int b = 0; b < len; b++) begin
            srcq[c].push_back({(b == len - 1), DATA_SIZE'($urandom())});
        end
    endtask

    task automatic model_reset();
        m_owner   = N_VC - 1;
        m_tlps    = 0;
        m_mid     = 0;
        m_started = 0;
        m_valid   = 0;
        m_data    = '0;
        m_last    = 0;
        m_vc      = 0;
        for (int i = 0; i < N_VC; i++) begin
            srcq[i].delete();
            want[i] = 0;
        end
        vc_log.delete();
    endtask

    task automatic drive();
        logic [N_VC-1:0]           v;
        logic [N_VC-1:0]           l;
        logic [N_VC*DATA_SIZE-1:0] d;
        logic [N_VC*WEIGHT_W-1:0]  w;
        logic [DATA_SIZE:0]        head;
        for (int i = 0; i < N_VC; i++) begin
            v[i] = present(i);
            if (v[i]) begin
                head = srcq[i][0];
                l[i] = head[DATA_SIZE];
                d[i*DATA_SIZE +: DATA_SIZE] = head[DATA_SIZE-1:0];
            end else begin
                l[i] = 1'($urandom_range(0, 1));
                d[i*DATA_SIZE +: DATA_SIZE] = DATA_SIZE'($urandom());
            end
            w[i*WEIGHT_W +: WEIGHT_W] = WEIGHT_W'(weight[i]);
        end
        bus.cfg_weight_i = w;
        bus.src_valid_i  = v;
        bus.src_last_i   = l;
        bus.src_data_i   = d;
        bus.dst_ready_i  = dready;
    endtask

    task automatic model_pick(output bit found, output int sel, output bit fresh);
        int c;
        found = 0;
        sel   = m_owner;
        fresh = 0;
        if (m_mid) begin
            found = 1;
        end else if (m_started && elig(m_owner) && (m_tlps < weight[m_owner])) begin
            found = 1;
        end else begin
            for (int k = 1; k <= N_VC; k++) begin
                c = (m_owner + k) % N_VC;
                if (!found && elig(c)) begin
                    found = 1;
                    sel   = c;
                    fresh = 1;
                end
            end
        end
    endtask

    task automatic step();
        bit                 found;
        bit                 fresh;
        int                 sel;
        logic [N_VC-1:0]    exp_rdy;
        logic [DATA_SIZE:0] beat;
        @(negedge clk);
        drive();
        #1;
        model_pick(found, sel, fresh);
        exp_rdy = '0;
        if (found && (!m_valid || dready)) exp_rdy[sel] = 1'b1;
        chk("src_ready", bus.src_ready_o, exp_rdy);
        if (m_valid && dready) vc_log.push_back(m_vc);
        if (found && (!m_valid || dready) && present(sel)) begin
            beat    = srcq[sel].pop_front();
            m_valid = 1;
            m_data  = beat[DATA_SIZE-1:0];
            m_last  = beat[DATA_SIZE];
            m_vc    = sel;
            m_tlps  = fresh ? int'(beat[DATA_SIZE]) : m_tlps + int'(beat[DATA_SIZE]);
            m_owner = sel;
            m_mid   = !beat[DATA_SIZE];
            m_started = 1;
        end else if (dready) begin
            m_valid = 0;
        end
        @(posedge clk);
        #1;
        chk("dst_valid", bus.dst_valid_o, m_valid);
        if (m_valid) begin
            chk("dst_data", bus.dst_data_o, m_data);
            chk("dst_last", bus.dst_last_o, m_last);
            chk("dst_vc", bus.dst_vc_o, m_vc);
        end
    endtask

    task automatic do_reset();
        @(negedge clk);
        #2 rst_n = 1'b0;
        #1;
        chk("rst_valid", bus.dst_valid_o, 0);
        chk("rst_data", bus.dst_data_o, 0);
        chk("rst_last", bus.dst_last_o, 0);
        chk("rst_vc", bus.dst_vc_o, 0);
        model_reset();
        drive();
        @(negedge clk);
        rst_n = 1'b1;
    endtask

    initial begin
        int pat1 [8] = '{0, 1, 1, 1, 0, 1, 1, 1};

        dready = 1;
        for (int i = 0; i < N_VC; i++) weight[i] = 1;
        model_reset();
        drive();
        do_reset();

        // Weights {1,3,0,0}: disabled ch2/ch3 stay valid but must never be readied
        weight = '{1, 3, 0, 0};
        for (int i = 0; i < N_VC; i++) begin
            want[i] = 1;
            for (int t = 0; t < 12; t++) push_tlp(i, 1);
        end
        for (int s = 0; s < 9; s++) step();
        chk("t1_log_size", vc_log.size(), 8);
        for (int i = 0; i < 8; i++) chk($sformatf("t1_vc%0d", i), vc_log[i], pat1[i]);

        // Equal weights, 3-beat TLPs, sources dropping valid mid-packet
        do_reset();
        weight = '{2, 2, 2, 2};
        for (int i = 0; i < N_VC; i++) for (int t = 0; t < 4; t++) push_tlp(i, 3);
        for (int s = 0; s < 70; s++) begin
            for (int i = 0; i < N_VC; i++) want[i] = ($urandom_range(0, 3) != 0);
            step();
        end

        // Single source streams back to back
        do_reset();
        weight = '{1, 1, 1, 1};
        want[2] = 1;
        for (int t = 0; t < 10; t++) push_tlp(2, 1);
        for (int s = 0; s < 12; s++) step();
        chk("t3_log_size", vc_log.size(), 10);
        for (int i = 0; i < vc_log.size(); i++) chk($sformatf("t3_vc%0d", i), vc_log[i], 2);

        // Backpressure: outputs hold and no source is readied
        do_reset();
        weight = '{1, 2, 1, 2};
        for (int i = 0; i < N_VC; i++) begin
            want[i] = 1;
            push_tlp(i, 2);
            push_tlp(i, 1);
        end
        step();
        dready = 0;
        for (int s = 0; s < 5; s++) step();
        dready = 1;
        for (int s = 0; s < 16; s++) step();
        chk("t4_beats", vc_log.size(), 12);

        // Weight lowered after ch1's first TLP of its phase hands the grant back to ch0
        do_reset();
        weight = '{1, 3, 0, 0};
        want[0] = 1;
        want[1] = 1;
        for (int t = 0; t < 6; t++) begin
            push_tlp(0, 1);
            push_tlp(1, 1);
        end
        step();
        step();
        weight[1] = 1;
        step();
        chk("t5_regrant_ch0", bus.dst_vc_o, 0);
        for (int s = 0; s < 4; s++) step();

        // Locked ch0 disabled mid-TLP: TLP completes, then ch0 is skipped
        do_reset();
        weight = '{2, 2, 0, 0};
        want[0] = 1;
        want[1] = 1;
        for (int t = 0; t < 3; t++) begin
            push_tlp(0, 3);
            push_tlp(1, 1);
        end
        step();
        weight[0] = 0;
        for (int s = 0; s < 8; s++) step();
        chk("t5_ch0_left", srcq[0].size(), 6);

        // Reset in the middle of a TLP, then lowest eligible channel wins
        do_reset();
        weight = '{1, 1, 1, 1};
        want[0] = 1;
        push_tlp(0, 3);
        step();
        step();
        do_reset();
        weight = '{1, 1, 1, 1};
        want[1] = 1;
        want[3] = 1;
        push_tlp(1, 1);
        push_tlp(3, 1);
        step();
        chk("t6_first_vc", bus.dst_vc_o, 1);
        step();

        // Randomized traffic, weights and backpressure
        do_reset();
        for (int s = 0; s < 400; s++) begin
            if (s % 25 == 0) for (int i = 0; i < N_VC; i++) weight[i] = $urandom_range(0, 4);
            for (int i = 0; i < N_VC; i++) begin
                want[i] = ($urandom_range(0, 3) != 0);
                if (srcq[i].size() < 4) push_tlp(i, $urandom_range(1, 4));
            end
            dready = ($urandom_range(0, 4) != 0);
            step();
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
